rr_hr_calc: RTL
===============

// Module: rr_hr_calc
// PURPOSE
//   Beat-interval processor directly upstream of the LCD UI display. Takes one-cycle
//   R-peak pulses from the ECG/ADC detector and produces the numbers the display shows:
//     - xinlv            : heart rate in bpm
//     - rr_current       : RR interval in ms
//     - hrv_sdnn         : HRV, as the averaged absolute successive RR difference in ms
//     - arrhythmia_level : rhythm classification
// PARAMETERS
//   CLK_FREQ   50_000_000  sys_clk frequency in Hz; one ms tick = CLK_FREQ/1000 cycles
//   RR_MIN_MS  250         refractory period; peaks closer than this are ignored
//   RR_MAX_MS  2000        longest accepted interval; also the beat-lost timeout
//   AVG_SHIFT  3           exponential-average weight, 1/2^AVG_SHIFT
// PORTS
//   sys_clk           in   1   system clock
//   sys_rst_n         in   1   asynchronous reset, active low
//   r_peak            in   1   one-cycle R-peak pulse, synchronous to sys_clk
//   xinlv             out  12  heart rate, bpm
//   rr_current        out  12  latest accepted RR interval, ms
//   hrv_sdnn          out  12  averaged |RR(n) - RR(n-1)|, ms
//   arrhythmia_level  out  2   0 normal, 1 mild, 2 severe, 3 beat lost
//   data_valid        out  1   one-cycle pulse when the outputs above are updated
// BEHAVIOUR
//   Reset: one clock; reset is asynchronous and active-low. All outputs, counters,
//     averages and the prev_rr register are 0. The FSM enters ARM.
//   ms_tick: free-running divider that pulses every CLK_FREQ/1000 cycles.
//   rr_cnt: counts ms_ticks and saturates at 4095.
//     - Cleared to 0 on every accepted or rejected peak.
//   FSM states: ARM, RUN, DIV, UPD.
//   ARM (no reference peak yet):
//     - r_peak -> clear rr_cnt, go to RUN.
//     - No outputs change.
//   RUN:
//     - r_peak with rr_cnt < RR_MIN_MS -> ignored. rr_cnt keeps counting.
//     - r_peak with RR_MIN_MS <= rr_cnt <= RR_MAX_MS -> accepted:
//       latch rr = rr_cnt, clear rr_cnt, go to DIV.
//     - r_peak with rr_cnt > RR_MAX_MS -> rejected: clear rr_cnt, stay in RUN (re-arm).
//       Outputs keep their values; no data_valid.
//     - When rr_cnt reaches RR_MAX_MS+1 on a tick, in the same cycle:
//       arrhythmia_level <= 3, xinlv <= 0, data_valid pulse. This fires once per gap.
//   DIV:
//     - Restoring divider computes 60000 / rr: 17-bit dividend, 12-bit divisor.
//     - The quotient is truncated. The divider takes exactly 17 cycles, then goes to UPD.
//     - r_peak arriving in DIV or UPD is ignored for output purposes.
//       rr_cnt still follows the RUN acceptance rules, so timing stays continuous.
//   UPD (single cycle), then back to RUN:
//     - xinlv <= quotient; rr_current <= rr.
//     - First accepted beat since reset (first flag):
//       avg <= rr, prev_rr <= rr, hrv_sdnn stays 0, level <= 0.
//     - Every later beat:
//       - d = |rr - avg|, computed with the avg from before this update.
//         level <= 2 if d > avg>>2; 1 if d > avg>>3; else 0.
//       - avg <= avg + ((rr - avg) >>> AVG_SHIFT), signed 14-bit arithmetic, truncated.
//       - hrv_sdnn <= hrv_sdnn + ((|rr - prev_rr| - hrv_sdnn) >>> AVG_SHIFT), signed.
//       - prev_rr <= rr.
//     - data_valid pulses in the UPD cycle.
//     - The total latency from the accepting r_peak to data_valid is 19 cycles.
//   Level 3 is cleared only by the next accepted beat.
//     - The first beat after a gap is rejected; the following beat is accepted.
//   Averages are kept across a beat-lost gap.
//   Reset asserted mid-DIV aborts the division; all outputs read 0.
// TESTING (CLK_FREQ = 1_000_000, so 1 ms = 1000 cycles)
//   1. Reset, peaks at t=0 and t=1000 ms -> rr_current=1000, xinlv=60, level=0,
//      hrv_sdnn=0; data_valid exactly 19 cycles after the 2nd peak.
//   2. Next peak 800 ms later -> rr_current=800, xinlv=75, avg=975; d=200 > 125 -> level=1;
//      hrv_sdnn=25.
//   3. Extra peak 100 ms after the last accepted one -> no data_valid, outputs unchanged;
//      a peak 1000 ms after the accepted one is still measured as 1000.
//   4. No peak for 2001 ms -> level=3, xinlv=0, one data_valid.
//      Peak at 2500 ms -> rejected; next peak 1000 ms later -> xinlv=60, level!=3.
//   5. Assert sys_rst_n low 5 cycles into DIV -> all outputs 0 immediately, FSM in ARM;
//      the next peak produces no data_valid.
//   6. Interval 250 ms -> xinlv=240 accepted; interval 249 ms -> ignored.

Source files
------------

// File: rtl/rr_hr_calc.sv
// Beat-interval processor: turns R-peak pulses into heart rate, RR interval,
// averaged successive-difference HRV and a rhythm class for the display.
module rr_hr_calc #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int RR_MIN_MS = 250,
  parameter int RR_MAX_MS = 2000,
  parameter int AVG_SHIFT = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        r_peak,
  output logic [11:0] xinlv,
  output logic [11:0] rr_current,
  output logic [11:0] hrv_sdnn,
  output logic [1:0]  arrhythmia_level,
  output logic        data_valid
);

  localparam int TICK_CYC = CLK_FREQ / 1000;
  localparam int TICK_W   = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [16:0] DIVIDEND = 17'd60000;

  typedef enum logic [1:0] {ARM, RUN, DIV, UPD} state_t;

  function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // acc + ((sample - acc) >>> AVG_SHIFT) in signed 14-bit, truncated back to 12 bits
  function automatic logic [11:0] ema_step(input logic [11:0] acc, input logic [11:0] sample);
    logic signed [13:0] diff;
    diff = $signed({2'b00, sample}) - $signed({2'b00, acc});
    return 12'($signed({2'b00, acc}) + (diff >>> AVG_SHIFT));
  endfunction

  function automatic logic [1:0] classify(input logic [11:0] d, input logic [11:0] avg);
    if (d > (avg >> 2))      return 2'd2;
    else if (d > (avg >> 3)) return 2'd1;
    else                     return 2'd0;
  endfunction

  state_t              state_q;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [11:0]         rr_cnt_q, rr_cnt_d;
  logic [11:0]         rr_q, rem_q, avg_q, prev_q;
  logic [16:0]         quo_q;
  logic [4:0]          bit_cnt_q;
  logic                seen_beat_q;
  logic [11:0]         xinlv_q, rr_cur_q, hrv_q;
  logic [1:0]          level_q;
  logic                dv_q;

  logic        ms_tick, in_refr, peak_clr, accept, timeout, fits;
  logic [12:0] trial;
  logic [11:0] rem_sub, rem_d;

  assign ms_tick  = (tick_cnt_q == TICK_W'(TICK_CYC - 1));
  assign in_refr  = (rr_cnt_q < 12'(RR_MIN_MS));
  // Any peak outside the refractory window restarts the interval, whatever the FSM is doing
  assign peak_clr = r_peak && ((state_q == ARM) || !in_refr);
  assign accept   = r_peak && !in_refr && (rr_cnt_q <= 12'(RR_MAX_MS));
  assign timeout  = !r_peak && ms_tick && (rr_cnt_q == 12'(RR_MAX_MS));

  always_comb begin
    tick_cnt_d = ms_tick ? '0 : tick_cnt_q + TICK_W'(1);
    rr_cnt_d   = rr_cnt_q;
    if (peak_clr)                             rr_cnt_d = '0;
    else if (ms_tick && rr_cnt_q != 12'hFFF)  rr_cnt_d = rr_cnt_q + 12'd1;
  end

  // One restoring step per DIV cycle; remainder always fits in 12 bits after a subtract
  assign trial   = {rem_q, quo_q[16]};
  assign fits    = (trial >= {1'b0, rr_q});
  assign rem_sub = 12'(trial - {1'b0, rr_q});
  assign rem_d   = fits ? rem_sub : trial[11:0];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tick_cnt_q <= '0;
      rr_cnt_q   <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      rr_cnt_q   <= rr_cnt_d;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ARM;
      rr_q        <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      bit_cnt_q   <= '0;
      avg_q       <= '0;
      prev_q      <= '0;
      seen_beat_q <= 1'b0;
      xinlv_q     <= '0;
      rr_cur_q    <= '0;
      hrv_q       <= '0;
      level_q     <= '0;
      dv_q        <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      case (state_q)
        ARM: if (r_peak) state_q <= RUN;
        RUN: begin
          if (accept) begin
            rr_q      <= rr_cnt_q;
            quo_q     <= DIVIDEND;
            rem_q     <= '0;
            bit_cnt_q <= '0;
            state_q   <= DIV;
          end else if (timeout) begin
            level_q <= 2'd3;
            xinlv_q <= '0;
            dv_q    <= 1'b1;
          end
        end
        DIV: begin
          quo_q     <= {quo_q[15:0], fits};
          rem_q     <= rem_d;
          bit_cnt_q <= bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd16) state_q <= UPD;
        end
        UPD: begin
          xinlv_q  <= quo_q[11:0];
          rr_cur_q <= rr_q;
          prev_q   <= rr_q;
          dv_q     <= 1'b1;
          state_q  <= RUN;
          if (!seen_beat_q) begin
            avg_q       <= rr_q;
            level_q     <= 2'd0;
            seen_beat_q <= 1'b1;
          end else begin
            level_q <= classify(abs_diff(rr_q, avg_q), avg_q);
            avg_q   <= ema_step(avg_q, rr_q);
            hrv_q   <= ema_step(hrv_q, abs_diff(rr_q, prev_q));
          end
        end
        default: state_q <= ARM;
      endcase
    end
  end

  assign xinlv            = xinlv_q;
  assign rr_current       = rr_cur_q;
  assign hrv_sdnn         = hrv_q;
  assign arrhythmia_level = level_q;
  assign data_valid       = dv_q;

endmodule
